// File: rtl/axis_upsizer.sv
// Narrow-to-wide AXI4-Stream packer: RATIO input beats (or fewer, closed early by tlast)
// form one registered output word, with tkeep marking the lanes that were filled.
module axis_upsizer #(
  parameter int S_DWIDTH     = 8,
  parameter int RATIO        = 4,
  parameter int S_KEEP_WIDTH = S_DWIDTH / 8,
  parameter int M_DWIDTH     = S_DWIDTH * RATIO,
  parameter int M_KEEP_WIDTH = S_KEEP_WIDTH * RATIO,
  parameter int ID_WIDTH     = 4,
  parameter int DEST_WIDTH   = 4,
  parameter int USER_WIDTH   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [S_DWIDTH-1:0]     s_axis_tdata,
  input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [ID_WIDTH-1:0]     s_axis_tid,
  input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [M_DWIDTH-1:0]     m_axis_tdata,
  output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [ID_WIDTH-1:0]     m_axis_tid,
  output logic [DEST_WIDTH-1:0]   m_axis_tdest,
  output logic [USER_WIDTH-1:0]   m_axis_tuser
);

  localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  logic [LW-1:0]           lane;
  logic [M_DWIDTH-1:0]     acc_data;
  logic [M_KEEP_WIDTH-1:0] acc_keep;
  logic [USER_WIDTH-1:0]   acc_user;
  logic [ID_WIDTH-1:0]     acc_id;
  logic [DEST_WIDTH-1:0]   acc_dest;

  logic [M_DWIDTH-1:0]     word_data;
  logic [M_KEEP_WIDTH-1:0] word_keep;
  logic [USER_WIDTH-1:0]   word_user;
  logic [ID_WIDTH-1:0]     word_id;
  logic [DEST_WIDTH-1:0]   word_dest;

  logic accept;
  logic complete;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign complete      = accept && ((lane == LAST_LANE) || s_axis_tlast);

  // Upper lanes of the accumulator are always zero, so merging the current beat
  // into its lane gives the complete word with unfilled lanes already cleared.
  always_comb begin
    word_data = acc_data;
    word_keep = acc_keep;
    for (int i = 0; i < RATIO; i++) begin
      if (lane == LW'(i)) begin
        word_data[i*S_DWIDTH +: S_DWIDTH]         = s_axis_tdata;
        word_keep[i*S_KEEP_WIDTH +: S_KEEP_WIDTH] = s_axis_tkeep;
      end
    end
    word_id   = (lane == '0) ? s_axis_tid   : acc_id;
    word_dest = (lane == '0) ? s_axis_tdest : acc_dest;
    word_user = acc_user | s_axis_tuser;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane          <= '0;
      acc_data      <= '0;
      acc_keep      <= '0;
      acc_user      <= '0;
      acc_id        <= '0;
      acc_dest      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      m_axis_tdest  <= '0;
      m_axis_tuser  <= '0;
    end else begin
      if (complete) begin
        m_axis_tdata  <= word_data;
        m_axis_tkeep  <= word_keep;
        m_axis_tlast  <= s_axis_tlast;
        m_axis_tid    <= word_id;
        m_axis_tdest  <= word_dest;
        m_axis_tuser  <= word_user;
        m_axis_tvalid <= 1'b1;
        lane          <= '0;
        acc_data      <= '0;
        acc_keep      <= '0;
        acc_user      <= '0;
      end else begin
        if (m_axis_tready) begin
          m_axis_tvalid <= 1'b0;
        end
        if (accept) begin
          acc_data <= word_data;
          acc_keep <= word_keep;
          acc_user <= word_user;
          acc_id   <= word_id;
          acc_dest <= word_dest;
          lane     <= lane + LW'(1);
        end
      end
    end
  end

endmodule

// File: doc/axis_upsizer.md
Name: axis_upsizer

Overview:
- Packs narrow AXI4-Stream beats into wide beats; RATIO input beats form one output beat.
- Sits directly downstream of the asynchronous stream FIFO in the m_clk domain; feeds wide datapath consumers such as DMA write and packet engines.
- Early tlast closes a partial word, and tkeep marks the valid lanes.
- Single clock; registered output, zero bubbles at full rate.

Parameters:
- S_DWIDTH, 8: input data width in bits; must be a multiple of 8.
- RATIO, 4: input beats per output beat; must be ≥2.
- S_KEEP_WIDTH, S_DWIDTH/8: input tkeep width.
- M_DWIDTH, S_DWIDTH*RATIO: output data width.
- M_KEEP_WIDTH, S_KEEP_WIDTH*RATIO: output tkeep width.
- ID_WIDTH, 4: tid width.
- DEST_WIDTH, 4: tdest width.
- USER_WIDTH, 1: tuser width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  S_DWIDTH  narrow data.
- s_axis_tkeep  in  S_KEEP_WIDTH  narrow byte enables.
- s_axis_tvalid  in  1  narrow valid.
- s_axis_tready  out  1  narrow ready.
- s_axis_tlast  in  1  end of packet.
- s_axis_tid  in  ID_WIDTH  stream id.
- s_axis_tdest  in  DEST_WIDTH  destination.
- s_axis_tuser  in  USER_WIDTH  sideband.
- m_axis_tdata  out  M_DWIDTH  wide data.
- m_axis_tkeep  out  M_KEEP_WIDTH  wide byte enables.
- m_axis_tvalid  out  1  wide valid.
- m_axis_tready  in  1  wide ready.
- m_axis_tlast  out  1  end of packet.
- m_axis_tid  out  ID_WIDTH  id of the word's lane-0 beat.
- m_axis_tdest  out  DEST_WIDTH  dest of the word's lane-0 beat.
- m_axis_tuser  out  USER_WIDTH  bitwise OR of tuser over the word's beats.

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst_n.
- Reset (rst_n=0, asynchronous):
  - lane counter, accumulator data/keep/user are cleared to 0.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, m_axis_tid=0, m_axis_tdest=0, m_axis_tuser=0.
  - A partial word held at reset is discarded.
  - s_axis_tready is 1 during and after reset, since it derives from m_axis_tvalid=0.
- Handshake:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready. It depends only on the register and m_axis_tready, never on s_axis_tvalid.
  - Input accepted on s_axis_tvalid && s_axis_tready.
  - Output transfer on m_axis_tvalid && m_axis_tready.
- Lane placement:
  - Accepted beat at lane k (0..RATIO-1) writes data bits [k*S_DWIDTH +: S_DWIDTH] and keep bits [k*S_KEEP_WIDTH +: S_KEEP_WIDTH].
  - Lane 0 occupies the LSBs.
  - Lane-0 beat latches tid and tdest; later beats' tid/tdest are ignored (upstream guarantees they are constant within a word).
- Word completion: an accepted beat completes the word when lane==RATIO-1 or s_axis_tlast=1.
  - On completion, the accumulator plus the current beat load the output register in the same edge; m_axis_tvalid=1 the next cycle.
  - m_axis_tlast = s_axis_tlast of the completing beat.
  - Unfilled upper lanes present data 0 and keep 0.
  - Lane counter returns to 0; accumulator data/keep/user clear.
- Non-completing accepted beat: written to the accumulator; lane increments.
- Latency: the completing input beat's edge is followed by m_axis_tvalid high at the next cycle (1 cycle).
- Throughput: with m_axis_tready held 1, one narrow beat is accepted every cycle with no bubbles.
- Output register hold: the register holds its contents stable while m_axis_tvalid && !m_axis_tready.
  - In that state s_axis_tready=0; the accumulator is frozen.
- Simultaneous events: output transfer and completing input on the same edge reload the register with the new word; m_axis_tvalid stays 1.
  - Output transfer with no completing input drops m_axis_tvalid to 0.
- Lane counter width is $clog2(RATIO). It never exceeds RATIO-1; it wraps to 0 only through completion.
- s_axis_tkeep is passed through unmodified. An all-zero tkeep beat still occupies a lane.
- tlast on lane 0 yields a single-lane word: keep = lane-0 keep only.

Test Plan:
- Full rate, default params: feed 8 beats 0x01..0x08, tkeep=1, tlast on beat 8, m_axis_tready=1 → two words, 0x04030201 (keep 0xF, tlast 0) then 0x08070605 (keep 0xF, tlast 1); no input stall; first m_axis_tvalid one cycle after beat 4 is accepted.
- Partial word: 6 beats 0xA0..0xA5, tlast on beat 6 → 0xA3A2A1A0 keep 0xF, then 0x0000A5A4 keep 0x3 tlast 1; lane counter back to 0.
- Back-pressure: hold m_axis_tready=0 after the first completed word → m_axis_tdata stable, s_axis_tready=0; release m_axis_tready → the word transfers and s_axis_tready=1 in the same cycle; no beat lost or duplicated (scoreboard over 1000 random beats with random valid/ready).
- Sideband: tuser=1 only on lane-2 beat, tid=3 on lane 0, tid=5 on lanes 1..3 → output tuser=1, tid=3.
- Reset mid-word: accept 2 beats, pull rst_n low asynchronously (off clock edge) → m_axis_tvalid=0 immediately; after release, 4 beats 0x11..0x14 → single word 0x14131211 with no residue from before reset.
- Single-beat packets: 3 consecutive tlast beats 0xB0, 0xB1, 0xB2 → three words 0x000000B0/B1/B2 each keep 0x1, tlast 1, back-to-back valid.
